// File: rtl/jtag_reg_bridge.sv
// ---------------------------------------------------------------------------
// jtag_reg_bridge
// Turns the ECP5 JTAGG user data registers into a register-bus master.
// Everything runs on the rising edge of jtck.
//   ER1 (command DR, CW bits)  : {data, addr, we}. Update-DR launches one transaction.
//   ER2 (status DR, SW bits)   : {rdata, err_ovr, err_to, busy}. Update-DR clears
//                                sticky errors whose bits are written as 1.
// Ports
//   jtck, jrstn                : JTAG clock, asynchronous active-low reset
//   jtdi, jshift, jupdate      : reclocked TDI, Shift-DR, one-cycle Update-DR pulse
//   jce1, jce2                 : one-cycle Capture-DR pulses for ER1 / ER2
//   jtdo1, jtdo2               : TDO for ER1 / ER2 (0 while the register is not selected)
//   bus_req/we/addr/wdata      : transaction request, held until ack or timeout
//   bus_rdata, bus_ack         : read data and one-cycle completion
//   busy                       : transaction in flight
// ---------------------------------------------------------------------------
module jtag_reg_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              jtck,
    input  logic              jrstn,
    input  logic              jtdi,
    input  logic              jshift,
    input  logic              jupdate,
    input  logic              jce1,
    input  logic              jce2,
    output logic              jtdo1,
    output logic              jtdo2,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              busy
);

    localparam int CW    = 1 + ADDR_W + DATA_W;
    localparam int SW    = DATA_W + 3;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ER1  = 2'd1,
        SEL_ER2  = 2'd2
    } sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    sel_e              sel_q,       sel_d;
    state_e            state_q,     state_d;
    logic [CW-1:0]     sr1_q,       sr1_d;
    logic [SW-1:0]     sr2_q,       sr2_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              req_q,       req_d;
    logic              busy_q,      busy_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              err_to_q,    err_to_d;
    logic              err_ovr_q,   err_ovr_d;
    logic              jshift_dly_q, jshift_dly_d;
    logic              jtdo1_q,     jtdo1_d;
    logic              jtdo2_q,     jtdo2_d;

    logic upd1_s;
    logic upd2_s;
    logic overrun_s;
    logic timeout_s;

    // Next-state logic for selection, shift registers, transaction FSM and status flags
    always_comb begin
        upd1_s    = jupdate && (sel_q == SEL_ER1);
        upd2_s    = jupdate && (sel_q == SEL_ER2);
        overrun_s = upd1_s && (state_q != ST_IDLE);
        timeout_s = (state_q == ST_REQ) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT));

        // Selection: captures pick a register, an update releases it.
        if (jce1) begin
            sel_d = SEL_ER1;
        end else if (jce2) begin
            sel_d = SEL_ER2;
        end else if (jupdate) begin
            sel_d = SEL_NONE;
        end else begin
            sel_d = sel_q;
        end

        // TDI lags jshift by one cycle, so the delayed flag marks the valid-bit window.
        jshift_dly_d = jshift;

        if (jce1) begin
            sr1_d = {wdata_q, addr_q, we_q};
        end else if (jshift_dly_q && (sel_q == SEL_ER1)) begin
            sr1_d = {jtdi, sr1_q[CW-1:1]};
        end else begin
            sr1_d = sr1_q;
        end

        if (jce2) begin
            sr2_d = {rdata_q, err_ovr_q, err_to_q, busy_q};
        end else if (jshift_dly_q && (sel_q == SEL_ER2)) begin
            sr2_d = {jtdi, sr2_q[SW-1:1]};
        end else begin
            sr2_d = sr2_q;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                // bus_ack while idle is deliberately ignored.
                if (upd1_s) begin
                    state_d = ST_REQ;
                    cnt_d   = {CNT_W{1'b0}};
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    we_d    = sr1_q[0];
                    addr_d  = sr1_q[ADDR_W:1];
                    wdata_d = sr1_q[CW-1:ADDR_W+1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Sticky errors: a set event in the same cycle beats a clear request.
        if (timeout_s) begin
            err_to_d = 1'b1;
        end else if (upd2_s && sr2_q[1]) begin
            err_to_d = 1'b0;
        end else begin
            err_to_d = err_to_q;
        end

        if (overrun_s) begin
            err_ovr_d = 1'b1;
        end else if (upd2_s && sr2_q[2]) begin
            err_ovr_d = 1'b0;
        end else begin
            err_ovr_d = err_ovr_q;
        end

        // TDO is registered from next-state values so it tracks sr[0] without lag.
        jtdo1_d = (sel_d == SEL_ER1) && sr1_d[0];
        jtdo2_d = (sel_d == SEL_ER2) && sr2_d[0];
    end

    // State registers with asynchronous reset to the all-zero idle state
    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) begin
            sel_q        <= SEL_NONE;
            state_q      <= ST_IDLE;
            sr1_q        <= {CW{1'b0}};
            sr2_q        <= {SW{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            rdata_q      <= {DATA_W{1'b0}};
            err_to_q     <= 1'b0;
            err_ovr_q    <= 1'b0;
            jshift_dly_q <= 1'b0;
            jtdo1_q      <= 1'b0;
            jtdo2_q      <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            state_q      <= state_d;
            sr1_q        <= sr1_d;
            sr2_q        <= sr2_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_to_q     <= err_to_d;
            err_ovr_q    <= err_ovr_d;
            jshift_dly_q <= jshift_dly_d;
            jtdo1_q      <= jtdo1_d;
            jtdo2_q      <= jtdo2_d;
        end
    end

    assign jtdo1     = jtdo1_q;
    assign jtdo2     = jtdo2_q;
    assign bus_req   = req_q;
    assign busy      = busy_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule
